// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB) with a
// parametrised memory wait/ready handshake and a retired-instruction counter.
// Optional feature: define ILLEGAL_TRAP_EN to send unsupported opcodes to TRAP.
module mc_control #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             rs_gtz,
    input  logic             mem_rdy,
    output logic             mem_req,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       regdst,
    output logic [1:0]       wb_sel,
    output logic             alusrc,
    output logic [2:0]       aluop,
    output logic [1:0]       extop,
    output logic             instr_done,
    output logic [CNT_W-1:0] icount,
    output logic [2:0]       state,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

    state_t     cur, nxt;
    logic [3:0] wcnt;
    logic       mem_state, done;

    // Instruction classification from the IR fields
    logic is_r, is_addu, is_subu, is_sll, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_bgtz, is_j, is_jal, is_alu_r, legal;

    assign is_r     = (op == 6'h00);
    assign is_addu  = is_r && (func == 6'h21);
    assign is_subu  = is_r && (func == 6'h23);
    assign is_sll   = is_r && (func == 6'h00);
    assign is_jr    = is_r && (func == 6'h08);
    assign is_ori   = (op == 6'h0D);
    assign is_lui   = (op == 6'h0F);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2B);
    assign is_beq   = (op == 6'h04);
    assign is_bgtz  = (op == 6'h07);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);
    assign is_alu_r = is_addu | is_subu | is_sll;
    assign legal    = is_alu_r | is_jr | is_ori | is_lui | is_lw | is_sw |
                      is_beq | is_bgtz | is_j | is_jal;

    // An access completes only in a memory state, after the wait has elapsed
    assign mem_state = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
    assign done      = mem_state && (wcnt == WAIT_MAX) && mem_rdy;
    assign state     = cur;

    // ALU controls shared by EXE and WB so the result stays stable into write-back
    logic [2:0] alu_op_d;
    logic       alu_src_d;
    logic [1:0] ext_op_d;
    always_comb begin
        alu_op_d  = 3'b000;
        alu_src_d = is_ori | is_lui | is_lw | is_sw;
        ext_op_d  = 2'b00;
        if (is_subu || is_beq || is_bgtz) alu_op_d = 3'b001;
        else if (is_ori)                  alu_op_d = 3'b010;
        else if (is_lui)                  alu_op_d = 3'b011;
        else if (is_sll)                  alu_op_d = 3'b100;
        if (is_lw || is_sw)               ext_op_d = 2'b01;
        else if (is_lui)                  ext_op_d = 2'b10;
    end

    // Next-state and output decode; reset forces every strobe low
    always_comb begin
        nxt        = cur;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        regdst     = 2'b00;
        wb_sel     = 2'b00;
        alusrc     = 1'b0;
        aluop      = 3'b000;
        extop      = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_req = 1'b1;
                if (done) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_en = 1'b1; pc_src = 2'b10; instr_done = 1'b1;
                end else if (is_jal) begin
                    pc_en = 1'b1; pc_src = 2'b10; reg_write = 1'b1;
                    regdst = 2'b10; wb_sel = 2'b10; instr_done = 1'b1;
                end else if (is_jr) begin
                    pc_en = 1'b1; pc_src = 2'b11; instr_done = 1'b1;
                end else if (legal) begin
                    nxt = S_EXE;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    nxt = S_TRAP;
`else
                    instr_done = 1'b1;
`endif
                end
            end
            S_EXE: begin
                aluop  = alu_op_d;
                alusrc = alu_src_d;
                extop  = ext_op_d;
                if (is_beq) begin
                    pc_en = zero; pc_src = 2'b01; instr_done = 1'b1;
                end else if (is_bgtz) begin
                    pc_en = rs_gtz; pc_src = 2'b01; instr_done = 1'b1;
                end else if (is_lw) begin
                    nxt = S_MEM_RD;
                end else if (is_sw) begin
                    nxt = S_MEM_WR;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                if (done) nxt = S_WB;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                if (done) instr_done = 1'b1;
            end
            S_WB: begin
                reg_write  = 1'b1;
                aluop      = alu_op_d;
                alusrc     = alu_src_d;
                extop      = ext_op_d;
                regdst     = is_alu_r ? 2'b01 : 2'b00;
                wb_sel     = is_lw ? 2'b01 : 2'b00;
                instr_done = 1'b1;
            end
            S_TRAP: begin
                nxt = S_TRAP;
`ifdef ILLEGAL_TRAP_EN
                illegal = 1'b1;
`endif
            end
            default: nxt = S_FETCH;
        endcase
        if (instr_done) nxt = S_FETCH;
        if (reset) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    // State, wait counter (cleared on any state change) and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cur    <= S_FETCH;
            wcnt   <= 4'd0;
            icount <= '0;
        end else begin
            cur <= nxt;
            if (nxt != cur)
                wcnt <= 4'd0;
            else if (mem_state && (wcnt != WAIT_MAX))
                wcnt <= wcnt + 4'd1;
            if (instr_done)
                icount <= icount + CNT_W'(1);
        end
    end

endmodule
